// File: rtl/sram_like_arbiter_if.sv
// One sram-like bus port: master drives the request side, slave answers with
// addr_ok/data_ok and read data.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, wen, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, wen, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_arbiter.sv
// Inst/data to single sram-like port arbiter: data has fixed priority, inst gets
// one forced grant after STARVE_LIMIT consecutive lost arbitrations.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_like_arbiter_if.slave    inst,
  sram_like_arbiter_if.slave    data,
  sram_like_arbiter_if.master   m
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} st_t;

  st_t              st, st_nx;
  logic             own, own_nx;
  logic [CNT_W-1:0] starve, starve_nx;
  logic             own_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st     <= IDLE;
      own    <= 1'b0;
      starve <= '0;
    end else begin
      st     <= st_nx;
      own    <= own_nx;
      starve <= starve_nx;
    end
  end

  always_comb begin
    st_nx        = st;
    own_nx       = own;
    starve_nx    = starve;
    own_req      = own ? data.req : inst.req;
    m.req        = 1'b0;
    m.wr         = 1'b0;
    m.size       = 2'b00;
    m.wen        = 4'b0000;
    m.addr       = 32'h0;
    m.wdata      = 32'h0;
    inst.addr_ok = 1'b0;
    inst.data_ok = 1'b0;
    inst.rdata   = 32'h0;
    data.addr_ok = 1'b0;
    data.data_ok = 1'b0;
    data.rdata   = 32'h0;
    case (st)
      IDLE: begin
        if (inst.req && data.req) begin
          st_nx = REQ;
          if (starve == CNT_W'(STARVE_LIMIT)) begin
            own_nx    = 1'b0;
            starve_nx = '0;
          end else begin
            own_nx    = 1'b1;
            starve_nx = starve + 1'b1;
          end
        end else if (data.req) begin
          st_nx  = REQ;
          own_nx = 1'b1;
        end else if (inst.req) begin
          st_nx     = REQ;
          own_nx    = 1'b0;
          starve_nx = '0;
        end
      end
      REQ: begin
        // Bus fields follow the owner's live inputs; the loser is held off.
        m.req = own_req;
        if (own) begin
          m.wr         = data.wr;
          m.size       = data.size;
          m.wen        = data.wen;
          m.addr       = data.addr;
          m.wdata      = data.wdata;
          data.addr_ok = m.addr_ok;
        end else begin
          m.wr         = inst.wr;
          m.size       = inst.size;
          m.wen        = inst.wr ? 4'b1111 : 4'b0000;
          m.addr       = inst.addr;
          m.wdata      = inst.wdata;
          inst.addr_ok = m.addr_ok;
        end
        if (!own_req)       st_nx = IDLE;
        else if (m.addr_ok) st_nx = RESP;
      end
      RESP: begin
        if (own) begin
          data.data_ok = m.data_ok;
          data.rdata   = m.data_ok ? m.rdata : 32'h0;
        end else begin
          inst.data_ok = m.data_ok;
          inst.rdata   = m.data_ok ? m.rdata : 32'h0;
        end
        if (m.data_ok) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: vector table plus multi-cycle sequences.
module tb_sram_like_arbiter;
  localparam logic T = 1'b1, F = 1'b0;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] IA  = 32'hBFC00000, DA  = 32'h80001000;
  localparam logic [31:0] IWD = 32'hA5A5A5A5, DWD = 32'h12345678;

  typedef struct {
    logic ireq, iwr, dreq, dwr; logic [3:0] dwen; logic aok, dok; logic [31:0] rd;
    logic e_mreq, e_mwr; logic [1:0] e_msize; logic [3:0] e_mwen;
    logic [31:0] e_maddr, e_mwdata;
    logic e_iaok, e_idok; logic [31:0] e_ird;
    logic e_daok, e_ddok; logic [31:0] e_drd;
  } vec_t;

  logic clk = 1'b0, resetn = 1'b0;
  int total = 0, bad = 0;
  vec_t tv [13];

  sram_like_arbiter_if inst_b();
  sram_like_arbiter_if data_b();
  sram_like_arbiter_if m_b();

  sram_like_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .inst(inst_b), .data(data_b), .m(m_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drv(input logic ireq, iwr, dreq, dwr, input logic [3:0] dwen,
                     input logic aok, dok, input logic [31:0] rd);
    inst_b.req = ireq; inst_b.wr = iwr;
    data_b.req = dreq; data_b.wr = dwr; data_b.wen = dwen;
    m_b.addr_ok = aok; m_b.data_ok = dok; m_b.rdata = rd;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic logic [159:0] all_out();
    return {20'h0, m_b.req, m_b.wr, m_b.size, m_b.wen, m_b.addr, m_b.wdata,
            inst_b.addr_ok, inst_b.data_ok, inst_b.rdata,
            data_b.addr_ok, data_b.data_ok, data_b.rdata};
  endfunction

  initial begin
    tv[0]  = '{F,F,F,F,4'h0,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[1]  = '{T,F,F,F,4'h0,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[2]  = '{T,F,F,F,4'h0,T,F,Z,            T,F,2'd2,4'h0,IA,IWD,T,F,Z,F,F,Z};
    tv[3]  = '{F,F,F,F,4'h0,F,T,32'h3C080001, F,F,2'd0,4'h0,Z,Z,F,T,32'h3C080001,F,F,Z};
    tv[4]  = '{F,F,F,F,4'h0,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[5]  = '{T,F,T,T,4'h3,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[6]  = '{T,F,T,T,4'h3,T,F,Z,            T,T,2'd1,4'h3,DA,DWD,F,F,Z,T,F,Z};
    tv[7]  = '{T,F,F,F,4'h0,F,T,32'h11112222, F,F,2'd0,4'h0,Z,Z,F,F,Z,F,T,32'h11112222};
    tv[8]  = '{T,T,F,F,4'h0,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[9]  = '{T,T,F,F,4'h0,T,F,Z,            T,T,2'd2,4'hF,IA,IWD,T,F,Z,F,F,Z};
    tv[10] = '{F,F,F,F,4'h0,F,T,32'h55667788, F,F,2'd0,4'h0,Z,Z,F,T,32'h55667788,F,F,Z};
    tv[11] = '{F,F,F,F,4'h0,F,T,32'hDEADBEEF, F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};
    tv[12] = '{F,F,F,F,4'h0,F,F,Z,            F,F,2'd0,4'h0,Z,Z,F,F,Z,F,F,Z};

    inst_b.size = 2'd2; inst_b.addr = IA; inst_b.wdata = IWD; inst_b.wen = 4'h0;
    data_b.size = 2'd1; data_b.addr = DA; data_b.wdata = DWD;

    // Outputs stay quiet in reset even with every input active.
    drv(T, T, T, T, 4'hF, T, T, 32'hFFFFFFFF);
    @(negedge clk);
    chk("reset_outputs", all_out(), 160'h0);
    chk("reset_state", {158'h0, dut.st}, 160'h0);
    drv(F, F, F, F, 4'h0, F, F, Z);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step();
      drv(tv[i].ireq, tv[i].iwr, tv[i].dreq, tv[i].dwr, tv[i].dwen, tv[i].aok, tv[i].dok, tv[i].rd);
      @(negedge clk);
      chk($sformatf("vec%0d", i), all_out(),
          {20'h0, tv[i].e_mreq, tv[i].e_mwr, tv[i].e_msize, tv[i].e_mwen, tv[i].e_maddr,
           tv[i].e_mwdata, tv[i].e_iaok, tv[i].e_idok, tv[i].e_ird,
           tv[i].e_daok, tv[i].e_ddok, tv[i].e_drd});
    end

    // Starvation: both held, 2-cycle slave; expect D D D D I repeating.
    begin
      int g = 0;
      int ms = 0;
      logic exp_i;
      logic [1:0] got_g;
      for (int c = 0; c < 30; c++) begin
        step();
        drv(T, F, T, F, 4'h0, T, T, 32'h0BADF00D);
        @(negedge clk);
        if (c % 3 == 0) begin
          chk($sformatf("starve_idle%0d", c), {157'h0, m_b.req, inst_b.addr_ok, data_b.addr_ok}, 160'h0);
        end else begin
          exp_i = (g % 5 == 4);
          if (c % 3 == 1) begin
            got_g = {inst_b.addr_ok, data_b.addr_ok};
            ms = exp_i ? 0 : ms + 1;
            chk($sformatf("starve_grant%0d", g), {158'h0, got_g}, {158'h0, exp_i, ~exp_i});
            chk($sformatf("starve_cnt%0d", g), {156'h0, dut.starve}, 160'(ms));
          end else begin
            got_g = {inst_b.data_ok, data_b.data_ok};
            chk($sformatf("starve_resp%0d", g), {158'h0, got_g}, {158'h0, exp_i, ~exp_i});
            g++;
          end
        end
      end
    end

    // Slave stall with inst owning the bus while data starts requesting.
    step(); drv(T, F, F, F, 4'h0, F, F, Z);
    @(negedge clk);
    chk("stall_idle", {158'h0, dut.st}, 160'h0);
    for (int k = 1; k <= 5; k++) begin
      step(); drv(T, F, T, F, 4'h5, F, (k == 3), 32'h77777777);
      @(negedge clk);
      chk($sformatf("stall_req%0d", k),
          {125'h0, m_b.req, m_b.addr, inst_b.addr_ok, inst_b.data_ok, data_b.addr_ok},
          {125'h0, T, IA, F, F, F});
    end
    step(); drv(T, F, T, F, 4'h5, T, F, Z);
    @(negedge clk);
    chk("stall_aok", {125'h0, m_b.req, m_b.addr, inst_b.addr_ok, inst_b.data_ok, data_b.addr_ok},
        {125'h0, T, IA, T, F, F});
    step(); drv(F, F, T, F, 4'h5, F, T, 32'hCAFE0001);
    @(negedge clk);
    chk("stall_resp", {123'h0, m_b.req, inst_b.addr_ok, inst_b.data_ok, inst_b.rdata, data_b.addr_ok, data_b.data_ok},
        {123'h0, F, F, T, 32'hCAFE0001, F, F});
    step(); drv(F, F, T, F, 4'h5, F, F, Z);
    @(negedge clk);
    chk("stall_idle2", {157'h0, m_b.req, inst_b.addr_ok, data_b.addr_ok}, 160'h0);
    step(); drv(F, F, T, F, 4'h5, T, F, Z);
    @(negedge clk);
    chk("stall_data_req", {121'h0, m_b.req, m_b.wen, m_b.addr, inst_b.addr_ok, data_b.addr_ok},
        {121'h0, T, 4'h5, DA, F, T});
    step(); drv(F, F, F, F, 4'h0, F, T, 32'hCAFE0002);
    @(negedge clk);
    chk("stall_data_resp", {126'h0, inst_b.data_ok, data_b.data_ok, data_b.rdata}, {126'h0, F, T, 32'hCAFE0002});
    step(); drv(F, F, F, F, 4'h0, F, F, Z);

    // Reset while waiting on data_ok; the late data_ok must be dropped.
    step(); drv(T, F, F, F, 4'h0, F, F, Z);
    step(); drv(T, F, F, F, 4'h0, T, F, Z);
    step(); drv(F, F, F, F, 4'h0, F, F, Z);
    @(negedge clk);
    chk("rst_in_resp", {158'h0, dut.st}, 160'd2);
    #1 resetn = 1'b0;
    #1 chk("rst_async", {158'h0, dut.st}, 160'h0);
    step(); resetn = 1'b1; drv(F, F, F, F, 4'h0, F, T, 32'h99999999);
    @(negedge clk);
    chk("rst_late_dok", {92'h0, dut.st, inst_b.data_ok, data_b.data_ok, inst_b.rdata, data_b.rdata}, 160'h0);
    step(); drv(F, F, F, F, 4'h0, F, F, Z);
    @(negedge clk);
    chk("rst_after", all_out(), 160'h0);

    // Owner drops its request in REQ before any addr_ok.
    step(); drv(F, F, T, T, 4'hF, F, F, Z);
    step(); drv(F, F, F, F, 4'h0, F, F, Z);
    @(negedge clk);
    chk("drop_req", {155'h0, dut.st, m_b.req, inst_b.addr_ok, data_b.addr_ok}, {155'h0, 2'd1, F, F, F});
    step(); drv(F, F, F, F, 4'h0, T, F, Z);
    @(negedge clk);
    chk("drop_idle", {155'h0, dut.st, m_b.req, inst_b.addr_ok, data_b.addr_ok}, 160'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
